fetch_decode_buffer: RTL

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

---
 rtl/fetch_decode_buffer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - fetch-to-decode pipeline buffer with valid/ready handshake on both sides
// Build option: define FD_SKID_BUF_EN for a two-entry skid buffer with a registered ready_f.
// Without it a single main entry is used and ready_f is combinational from ready_d.
module fetch_decode_buffer #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_f,
  output logic            ready_f,
  input  logic [ILEN-1:0] instr_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pc_plus4_f,
  input  logic            flush,
  output logic            valid_d,
  input  logic            ready_d,
  output logic [ILEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
);

  logic            main_vld;
  logic [ILEN-1:0] main_instr_q;
  logic [XLEN-1:0] main_pc_q;
  logic [XLEN-1:0] main_pc4_q;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = valid_f & ready_f;
  assign out_xfer = main_vld & ready_d;

  // Decode sees the main entry straight from registers; an empty slot shows a NOP at PC 0.
  assign valid_d    = main_vld;
  assign instr_d    = main_vld ? main_instr_q : NOP_INSTR;
  assign pc_d       = main_vld ? main_pc_q    : '0;
  assign pc_plus4_d = main_vld ? main_pc4_q   : '0;

`ifdef FD_SKID_BUF_EN

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            ready_q;
  logic [ILEN-1:0] skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_pc4_q;
  logic            load_main;
  logic            load_skid;
  logic            move_skid;

  assign main_vld = (state_q != S_EMPTY);
  // ready_q is a flop, so ready_d never reaches ready_f within a cycle; rst_n only gates it off in reset.
  assign ready_f  = rst_n & ready_q;

  // Occupancy transitions; flush beats any transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_xfer) state_d = S_ONE;
        S_ONE: begin
          if (in_xfer && !out_xfer)      state_d = S_TWO;
          else if (out_xfer && !in_xfer) state_d = S_EMPTY;
        end
        S_TWO:   if (out_xfer) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign load_main = !flush && in_xfer &&
                     ((state_q == S_EMPTY) || ((state_q == S_ONE) && out_xfer));
  assign load_skid = !flush && in_xfer && (state_q == S_ONE) && !out_xfer;
  assign move_skid = !flush && out_xfer && (state_q == S_TWO);

  // State and ready register; ready comes up high right out of reset so fetch can start at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_TWO);
    end
  end

  // Payload storage: main takes fetch data or the skid entry, skid catches data while decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else begin
      if (load_main) begin
        main_instr_q <= instr_f;
        main_pc_q    <= pc_f;
        main_pc4_q   <= pc_plus4_f;
      end else if (move_skid) begin
        main_instr_q <= skid_instr_q;
        main_pc_q    <= skid_pc_q;
        main_pc4_q   <= skid_pc4_q;
      end
      if (load_skid) begin
        skid_instr_q <= instr_f;
        skid_pc_q    <= pc_f;
        skid_pc4_q   <= pc_plus4_f;
      end
    end
  end

`else

  logic main_vld_q;
  logic main_vld_d;

  assign main_vld = main_vld_q;
  // A stalled full entry blocks fetch; a consuming decode frees the slot in the same cycle.
  assign ready_f  = rst_n & (ready_d | ~main_vld_q);

  // Valid bit next state; flush wins, a new input keeps the slot full across an output transfer.
  always_comb begin
    main_vld_d = main_vld_q;
    if (flush)         main_vld_d = 1'b0;
    else if (in_xfer)  main_vld_d = 1'b1;
    else if (out_xfer) main_vld_d = 1'b0;
  end

  // Main entry register: valid bit and payload captured on every accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q   <= 1'b0;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      if (in_xfer && !flush) begin
        main_instr_q <= instr_f;
        main_pc_q    <= pc_f;
        main_pc4_q   <= pc_plus4_f;
      end
    end
  end

`endif

endmodule
